arm_dmem_responder: RTL and testbench
=====================================

Name: arm_dmem_responder

Overview:
- Data-memory responder on the far side of the single-cycle ARM core's data bus. It consumes MemWrite, ALUResult (address) and WriteData, and returns ReadData.
- Maps a word RAM plus a small peripheral page: a free-running timer with compare, a sticky match flag and a GPIO output register.
- Read data is combinational, because the single-cycle core samples ReadData in the same cycle. All state updates on the rising clock edge.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; power of two, 4..1024.
- PRESCALE, 1, clock cycles per timer increment; must be ≥1.

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- MemWrite  input  1  write strobe, sampled on rising clk
- ALUResult  input  32  byte address; bits [1:0] ignored
- WriteData  input  32  store data
- ReadData  output  32  load data, combinational from ALUResult
- gpio_out  output  32  GPIO_OUT register value

Behaviour:
- Address decode (addr = ALUResult):
  - RAM: addr[31:2+log2(RAM_WORDS)] == 0; word index = addr[log2(RAM_WORDS)+1:2].
  - Peripheral page: addr[31:4] == 28'h8000000. Offsets: 0x0 TIMER_COUNT (RO), 0x4 TIMER_CMP (RW), 0x8 STATUS (bit0 MATCH, W1C), 0xC GPIO_OUT (RW).
  - Anything else is unmapped: reads return 32'h0, writes are ignored.
- Reads: ReadData is a pure function of addr and current state; no latency. STATUS reads return {31'b0, MATCH}, or per the optional feature below.
- Writes: take effect on the rising edge when MemWrite=1. A read of the same address in the next cycle returns the new value. Writes to TIMER_COUNT are ignored.
- Reset (reset=0, asynchronous): TIMER_COUNT=0, prescale counter=0, TIMER_CMP=32'hFFFF_FFFF, MATCH=0, GPIO_OUT=0, so gpio_out=0.
  - RAM contents are not reset and are undefined until written.
  - Reset asserted mid-write aborts the write; the peripheral registers hold their reset values.
- Prescaler: counts 0..PRESCALE-1 and wraps. tick=1 on the cycle it equals PRESCALE-1. With PRESCALE=1, tick=1 every cycle.
- Timer: on each edge with tick=1, TIMER_COUNT <= TIMER_COUNT+1, mod 2^32 (0xFFFF_FFFF wraps to 0).
- Match: on an edge with tick=1 and TIMER_COUNT+1 == TIMER_CMP, MATCH <= 1. MATCH is sticky.
- STATUS write with WriteData[0]=1 clears MATCH; WriteData[0]=0 has no effect.
- Same-edge set and clear: set wins, so MATCH stays 1.
- A TIMER_CMP write takes effect for comparisons from the next edge on.
- The state machine is implicit: the prescaler state plus the MATCH flag (IDLE=0 / MATCHED=1). MATCHED returns to IDLE only on a W1C write.

Optional Feature:
- Macro ARM_DMEM_IRQ_EN.
- When defined:
  - Adds output port irq (1 bit).
  - STATUS bit1 becomes IRQ_EN (RW, reset 0); STATUS writes update bit1 from WriteData[1].
  - irq = MATCH & IRQ_EN, registered, so it asserts one cycle after the enabling condition becomes true.
- When undefined:
  - No irq port.
  - STATUS bit1 reads 0 and writes to it are ignored.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release → gpio_out=0; read 0x8000_0004 → 0xFFFF_FFFF; read 0x8000_0008 → 0; read 0x8000_0000 → 0 in the first cycle after release.
- RAM: write 0x1234_5678 to 0x10 and 0xCAFE_F00D to 0xFC (RAM_WORDS=64) → reads return those values. Read 0x13 → 0x1234_5678 (bits [1:0] ignored). Write to 0x100, then read → 0, and RAM word 0 is unchanged.
- Timer/match (PRESCALE=4): write CMP=5 → TIMER_COUNT increments every 4 cycles; MATCH rises on the edge where the count becomes 5 and stays 1 after the count reaches 6.
- W1C: with MATCH=1, write STATUS=0 → MATCH stays 1; write STATUS=1 → reads 0. With PRESCALE=1 and CMP = count+2, issue the clear on the edge where the count becomes CMP → MATCH=1 (set wins).
- GPIO/unmapped: write 0xA5A5_0001 to 0x8000_000C → gpio_out=0xA5A5_0001 after the edge. Write to 0x8000_0010 and 0x4000_0000 → no state change; both read 0.
- IRQ (ARM_DMEM_IRQ_EN): MATCH=1, write STATUS=0x2 → irq=1 one cycle later; write STATUS=0x3 → MATCH=0, irq=0 one cycle later. With the macro undefined, STATUS bit1 reads 0.

Source files
------------

// File: rtl/arm_dmem_responder_if.sv
// -----------------------------------------------------------------------------
// arm_dmem_responder_if
//
// Data-bus bundle between the single-cycle ARM core (master) and the data
// memory responder (slave).
//
// Signals:
//   MemWrite  [0:0]   master -> slave  write strobe, sampled on rising clk
//   ALUResult [31:0]  master -> slave  byte address (bits [1:0] ignored)
//   WriteData [31:0]  master -> slave  store data
//   ReadData  [31:0]  slave  -> master load data, combinational from ALUResult
// -----------------------------------------------------------------------------
interface arm_dmem_responder_if;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  // Core side: drives address, strobe and store data, receives load data.
  modport master (
    output MemWrite,
    output ALUResult,
    output WriteData,
    input  ReadData
  );

  // Memory side: receives the request, returns load data.
  modport slave (
    input  MemWrite,
    input  ALUResult,
    input  WriteData,
    output ReadData
  );
endinterface : arm_dmem_responder_if

// File: rtl/arm_dmem_responder.sv
// -----------------------------------------------------------------------------
// arm_dmem_responder
//
// Data-memory responder for the single-cycle ARM core. Decodes the core's data
// bus into a word RAM and a four-register peripheral page:
//   0x8000_0000  TIMER_COUNT  RO   free-running counter, advances on tick
//   0x8000_0004  TIMER_CMP    RW   compare value, reset 0xFFFF_FFFF
//   0x8000_0008  STATUS       bit0 MATCH (sticky, write-1-to-clear)
//                                   bit1 IRQ_EN (only with ARM_DMEM_IRQ_EN)
//   0x8000_000C  GPIO_OUT     RW   drives gpio_out
// Everything else is unmapped: reads return 0, writes are dropped.
//
// Reads are combinational so the core can sample ReadData in the same cycle;
// all state changes on the rising edge of clk.
//
// Parameters:
//   RAM_WORDS  number of 32-bit RAM words (power of two, 4..1024)
//   PRESCALE   clock cycles per timer increment (>= 1)
//
// Ports:
//   clk       input   core clock
//   reset     input   asynchronous, active-low reset
//   bus       slave   data bus (MemWrite, ALUResult, WriteData, ReadData)
//   gpio_out  output  current GPIO_OUT register value
//   irq       output  registered MATCH & IRQ_EN (only with ARM_DMEM_IRQ_EN)
//
// Build option:
//   ARM_DMEM_IRQ_EN  when defined, adds the irq port and the IRQ_EN bit in
//                    STATUS; when undefined STATUS bit1 reads 0.
// -----------------------------------------------------------------------------
module arm_dmem_responder #(
  parameter int RAM_WORDS = 64,
  parameter int PRESCALE  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  arm_dmem_responder_if.slave        bus,
  output logic [31:0]                gpio_out
`ifdef ARM_DMEM_IRQ_EN
  ,
  output logic                       irq
`endif
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int AW = $clog2(RAM_WORDS);
  // A one-bit prescale counter is kept even for PRESCALE=1; it never leaves 0.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  localparam logic [27:0] PERIPH_PAGE = 28'h800_0000;

  localparam logic [1:0] OFF_COUNT  = 2'd0;
  localparam logic [1:0] OFF_CMP    = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_GPIO   = 2'd3;

  // MATCH flag viewed as a two-state machine.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MATCHED = 1'b1
  } match_state_e;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [31:0]   addr;
  logic          ram_sel;
  logic          per_sel;
  logic [AW-1:0] ram_idx;
  logic [1:0]    reg_off;
  logic          unused_addr_bits;

  assign addr     = bus.ALUResult;
  assign ram_sel  = (addr[31:AW+2] == '0);
  assign per_sel  = (addr[31:4] == PERIPH_PAGE);
  assign ram_idx  = addr[AW+1:2];
  assign reg_off  = addr[3:2];
  // Byte-lane bits play no part in word addressing.
  assign unused_addr_bits = ^addr[1:0];

  // Write strobes per target. TIMER_COUNT has no strobe: it is read-only.
  logic wr_ram;
  logic wr_cmp;
  logic wr_status;
  logic wr_gpio;

  assign wr_ram    = bus.MemWrite & ram_sel;
  assign wr_cmp    = bus.MemWrite & per_sel & (reg_off == OFF_CMP);
  assign wr_status = bus.MemWrite & per_sel & (reg_off == OFF_STATUS);
  assign wr_gpio   = bus.MemWrite & per_sel & (reg_off == OFF_GPIO);

  // ---------------------------------------------------------------------------
  // Word RAM: no reset, combinational read port, synchronous write port.
  // ---------------------------------------------------------------------------
  logic [31:0] ram_q [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_ram) begin
      ram_q[ram_idx] <= bus.WriteData;
    end
  end

  // ---------------------------------------------------------------------------
  // Peripheral state
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   cmp_q,   cmp_d;
  logic [31:0]   gpio_q,  gpio_d;
  match_state_e  state_q, state_d;
`ifdef ARM_DMEM_IRQ_EN
  logic          irq_en_q, irq_en_d;
  logic          irq_q,    irq_d;
`endif

  logic tick;
  logic match_hit;
  logic match_clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q  <= '0;
      count_q  <= '0;
      cmp_q    <= 32'hFFFF_FFFF;
      gpio_q   <= '0;
      state_q  <= ST_IDLE;
`ifdef ARM_DMEM_IRQ_EN
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
`endif
    end else begin
      presc_q  <= presc_d;
      count_q  <= count_d;
      cmp_q    <= cmp_d;
      gpio_q   <= gpio_d;
      state_q  <= state_d;
`ifdef ARM_DMEM_IRQ_EN
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
`endif
    end
  end

  // Next-state logic for prescaler, timer, compare, GPIO and MATCH.
  always_comb begin
    presc_d   = presc_q;
    count_d   = count_q;
    cmp_d     = cmp_q;
    gpio_d    = gpio_q;
    state_d   = state_q;
    tick      = 1'b0;
    match_hit = 1'b0;
    match_clr = 1'b0;
`ifdef ARM_DMEM_IRQ_EN
    irq_en_d  = irq_en_q;
    irq_d     = 1'b0;
`endif

    // Prescaler wraps at PRESCALE-1 and emits tick on that cycle.
    tick = (presc_q == PRESC_LAST);
    if (tick) begin
      presc_d = '0;
      count_d = count_q + 32'd1;  // wraps naturally mod 2^32
    end else begin
      presc_d = presc_q + 1'b1;
    end

    // Compare against the value the counter is about to take, using the
    // currently registered TIMER_CMP: a CMP write on this edge only affects
    // later edges.
    match_hit = tick && ((count_q + 32'd1) == cmp_q);
    match_clr = wr_status && bus.WriteData[0];

    unique case (state_q)
      ST_IDLE: begin
        if (match_hit) begin
          state_d = ST_MATCHED;
        end
      end
      ST_MATCHED: begin
        // A clear on the same edge as a fresh match loses: the flag stays set.
        if (match_clr && !match_hit) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_cmp) begin
      cmp_d = bus.WriteData;
    end
    if (wr_gpio) begin
      gpio_d = bus.WriteData;
    end

`ifdef ARM_DMEM_IRQ_EN
    if (wr_status) begin
      irq_en_d = bus.WriteData[1];
    end
    // Built from registered values, so irq lags the enabling condition by
    // exactly one cycle.
    irq_d = (state_q == ST_MATCHED) && irq_en_q;
`endif
  end

  // ---------------------------------------------------------------------------
  // Read mux (combinational)
  // ---------------------------------------------------------------------------
  logic [31:0] status_rd;
  logic [31:0] rdata;

`ifdef ARM_DMEM_IRQ_EN
  assign status_rd = {30'b0, irq_en_q, (state_q == ST_MATCHED)};
`else
  assign status_rd = {31'b0, (state_q == ST_MATCHED)};
`endif

  always_comb begin
    rdata = '0;
    if (ram_sel) begin
      rdata = ram_q[ram_idx];
    end else if (per_sel) begin
      unique case (reg_off)
        OFF_COUNT:  rdata = count_q;
        OFF_CMP:    rdata = cmp_q;
        OFF_STATUS: rdata = status_rd;
        OFF_GPIO:   rdata = gpio_q;
        default:    rdata = '0;
      endcase
    end
  end

  assign bus.ReadData = rdata;
  assign gpio_out     = gpio_q;
`ifdef ARM_DMEM_IRQ_EN
  assign irq          = irq_q;
`endif

endmodule : arm_dmem_responder

// File: tb/tb_arm_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_arm_dmem_responder
//
// Directed bench for arm_dmem_responder. Two instances share clock and reset:
// dut4 (PRESCALE=4) for the timer/match/W1C/RAM/GPIO checks and dut1
// (PRESCALE=1) for the same-edge set-versus-clear case. Inputs change 1 ns
// after a rising edge; combinational reads are sampled 1 ns after the address
// is applied, well before the next edge.
// -----------------------------------------------------------------------------
module tb_arm_dmem_responder;

  localparam logic [31:0] A_COUNT  = 32'h8000_0000;
  localparam logic [31:0] A_CMP    = 32'h8000_0004;
  localparam logic [31:0] A_STATUS = 32'h8000_0008;
  localparam logic [31:0] A_GPIO   = 32'h8000_000C;

`ifdef ARM_DMEM_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] gpio4;
  logic [31:0] gpio1;
`ifdef ARM_DMEM_IRQ_EN
  logic        irq4;
  logic        irq1;
`endif

  always #5 clk = ~clk;

  arm_dmem_responder_if bus4();
  arm_dmem_responder_if bus1();

  arm_dmem_responder #(.RAM_WORDS(64), .PRESCALE(4)) dut4 (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus4),
    .gpio_out (gpio4)
`ifdef ARM_DMEM_IRQ_EN
    ,
    .irq      (irq4)
`endif
  );

  arm_dmem_responder #(.RAM_WORDS(64), .PRESCALE(1)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus1),
    .gpio_out (gpio1)
`ifdef ARM_DMEM_IRQ_EN
    ,
    .irq      (irq1)
`endif
  );

  int tests = 0;
  int fails = 0;
  int ecnt  = 0;   // rising edges since reset release

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp_v);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) step_clk();
  endtask

  // One-cycle write; the strobe drops again right after the edge.
  task automatic wr(input int which, input logic [31:0] a, input logic [31:0] d);
    if (which == 4) begin
      bus4.MemWrite  = 1'b1;
      bus4.ALUResult = a;
      bus4.WriteData = d;
    end else begin
      bus1.MemWrite  = 1'b1;
      bus1.ALUResult = a;
      bus1.WriteData = d;
    end
    step_clk();
    bus4.MemWrite = 1'b0;
    bus1.MemWrite = 1'b0;
    $display("[TB] t=%0t dut%0d write %08h <= %08h", $time, which, a, d);
  endtask

  // Combinational read, no clock edge consumed.
  task automatic rd(input int which, input logic [31:0] a, input string tag,
                    input logic [31:0] exp_v);
    logic [31:0] obs;
    if (which == 4) begin
      bus4.MemWrite  = 1'b0;
      bus4.ALUResult = a;
    end else begin
      bus1.MemWrite  = 1'b0;
      bus1.ALUResult = a;
    end
    #1;
    obs = (which == 4) ? bus4.ReadData : bus1.ReadData;
    $display("[TB] t=%0t dut%0d read  %08h -> %08h (want %08h)", $time, which, a, obs, exp_v);
    check(tag, obs, exp_v);
  endtask

  initial begin
    int c;

    bus4.MemWrite = 1'b0; bus4.ALUResult = '0; bus4.WriteData = '0;
    bus1.MemWrite = 1'b0; bus1.ALUResult = '0; bus1.WriteData = '0;

    // ---- Reset: held low for three edges, released 1 ns after the third.
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    ecnt  = 0;

    check("reset_gpio", gpio4, 32'h0);
    rd(4, A_CMP,    "reset_cmp",    32'hFFFF_FFFF);
    rd(4, A_STATUS, "reset_status", 32'h0);
    rd(4, A_COUNT,  "reset_count4", 32'h0);
    rd(1, A_COUNT,  "reset_count1", 32'h0);

    // ---- Timer and match with PRESCALE=4: count becomes n on edge 4n.
    wr(4, A_CMP, 32'd5);                         // edge 1
    cyc(2);                                      // edge 3
    rd(4, A_COUNT, "cnt_e3", 32'd0);
    cyc(1);                                      // edge 4
    rd(4, A_COUNT, "cnt_e4", 32'd1);
    cyc(3);                                      // edge 7
    rd(4, A_COUNT, "cnt_e7", 32'd1);
    cyc(1);                                      // edge 8
    rd(4, A_COUNT, "cnt_e8", 32'd2);
    cyc(11);                                     // edge 19
    rd(4, A_COUNT,  "cnt_e19",    32'd4);
    rd(4, A_STATUS, "match_e19",  32'd0);
    cyc(1);                                      // edge 20
    rd(4, A_COUNT,  "cnt_e20",    32'd5);
    rd(4, A_STATUS, "match_e20",  32'd1);
    cyc(4);                                      // edge 24
    rd(4, A_COUNT,  "cnt_e24",    32'd6);
    rd(4, A_STATUS, "match_stick", 32'd1);

    // ---- W1C: writing 0 leaves MATCH, bit1 only exists in the IRQ build.
    wr(4, A_STATUS, 32'h0);
    rd(4, A_STATUS, "w1c_zero", 32'd1);
    wr(4, A_STATUS, 32'h2);
    rd(4, A_STATUS, "status_bit1", IRQ_BUILD ? 32'd3 : 32'd1);
`ifdef ARM_DMEM_IRQ_EN
    check("irq_lag0", {31'b0, irq4}, 32'd0);
    cyc(1);
    check("irq_on", {31'b0, irq4}, 32'd1);
`endif
    wr(4, A_STATUS, IRQ_BUILD ? 32'h3 : 32'h1);
    rd(4, A_STATUS, "w1c_one", IRQ_BUILD ? 32'd2 : 32'd0);
`ifdef ARM_DMEM_IRQ_EN
    check("irq_lag1", {31'b0, irq4}, 32'd1);
    cyc(1);
    check("irq_off", {31'b0, irq4}, 32'd0);
`endif

    // ---- Set wins over clear on the same edge (dut1 count == ecnt).
    c = ecnt;
    wr(1, A_CMP, 32'(c + 2));                    // count becomes c+1
    wr(1, A_STATUS, 32'h1);                      // count becomes c+2 == CMP
    rd(1, A_COUNT,  "setwin_cnt",    32'(c + 2));
    rd(1, A_STATUS, "setwin_match",  32'd1);
    wr(1, A_STATUS, 32'h1);
    rd(1, A_STATUS, "setwin_clear",  32'd0);

    // ---- RAM.
    wr(4, 32'h0000_0000, 32'h0BAD_BEEF);
    wr(4, 32'h0000_0010, 32'h1234_5678);
    wr(4, 32'h0000_00FC, 32'hCAFE_F00D);
    rd(4, 32'h0000_0010, "ram_10",  32'h1234_5678);
    rd(4, 32'h0000_00FC, "ram_fc",  32'hCAFE_F00D);
    rd(4, 32'h0000_0013, "ram_13",  32'h1234_5678);
    wr(4, 32'h0000_0100, 32'h5555_AAAA);
    rd(4, 32'h0000_0100, "unmap_100", 32'h0);
    rd(4, 32'h0000_0000, "ram_0_kept", 32'h0BAD_BEEF);

    // ---- GPIO and unmapped peripheral space.
    wr(4, A_GPIO, 32'hA5A5_0001);
    check("gpio_out", gpio4, 32'hA5A5_0001);
    rd(4, A_GPIO, "gpio_rd", 32'hA5A5_0001);
    wr(4, 32'h8000_0010, 32'hFFFF_FFFF);
    wr(4, 32'h4000_0000, 32'hFFFF_FFFF);
    rd(4, 32'h8000_0010, "unmap_8010", 32'h0);
    rd(4, 32'h4000_0000, "unmap_4000", 32'h0);
    check("gpio_unchg", gpio4, 32'hA5A5_0001);
    rd(4, A_CMP, "cmp_unchg", 32'd5);

    // ---- Asynchronous reset in the middle of a GPIO write.
    bus4.MemWrite  = 1'b1;
    bus4.ALUResult = A_GPIO;
    bus4.WriteData = 32'h1234_5678;
    reset = 1'b0;
    #1;
    check("async_rst_gpio", gpio4, 32'h0);
    step_clk();
    check("rst_wr_abort", gpio4, 32'h0);
    bus4.MemWrite = 1'b0;
    rd(4, A_CMP,    "rst_cmp",    32'hFFFF_FFFF);
    rd(4, A_STATUS, "rst_status", 32'h0);
    reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_arm_dmem_responder
